// File: rtl/eth_rx_frame_mux.sv
// eth_rx_frame_mux: merges CH_COUNT MAC receive streams into one tagged byte
// stream. Each channel stores bytes in its own frame FIFO. Only frames that
// end cleanly are committed; committed frames are replayed whole, round-robin.

// Per-channel frame store: write FSM, commit/rewind pointers, 9-bit BRAM
// ({last, byte}), frame counter and saturating drop counter.
module eth_rx_frame_ch #(
  parameter int DEPTH = 2048,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_sof,
  input  logic             rx_eof,
  input  logic             rx_crc_good,
  input  logic             rx_fr_err,
  input  logic             rd_req,     // issue a RAM read this cycle
  input  logic             rd_adv,     // advance rd (byte handed off)
  input  logic             frm_pop,    // last byte of a frame handed off
  output logic [8:0]       rd_q,
  output logic             avail,
  output logic             frm_drop,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  logic [1:0]    state, state_nx;
  logic [AW:0]   wr, cmt, rd;
  logic [AW:0]   wr_nx, cmt_nx, base, base_p1, used, rd_p1;
  logic [AW:0]   frm_cnt;
  logic          wr_en, push, drop;
  logic [8:0]    wr_word;
  logic [AW-1:0] rd_addr;
  logic [8:0]    mem [DEPTH];

  assign rd_p1   = rd + PTR_ONE;
  assign rd_addr = rd_adv ? rd_p1[AW-1:0] : rd[AW-1:0];
  // A new frame always begins at the commit point; a frame in progress
  // continues at wr. Occupancy is measured against rd so unread bytes are
  // never overwritten.
  assign base    = (rx_sof || state != S_RECV) ? cmt : wr;
  assign base_p1 = base + PTR_ONE;
  assign used    = base - rd;
  assign avail   = |frm_cnt;

  // Write-side next state: accept, restart, overflow-discard or commit.
  always_comb begin
    state_nx = state;
    wr_nx    = wr;
    cmt_nx   = cmt;
    wr_en    = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    wr_word  = {1'b0, rx_data};
    if (rx_valid) begin
      if (rx_sof || state == S_RECV) begin
        // sof inside a frame abandons the partial frame
        if (rx_sof && state == S_RECV) drop = 1'b1;
        if (used == FULL) begin
          drop     = 1'b1;
          wr_nx    = cmt;
          state_nx = rx_eof ? S_IDLE : S_DISC;
        end else begin
          wr_en   = 1'b1;
          wr_word = {rx_eof & rx_crc_good & ~rx_fr_err, rx_data};
          if (rx_eof) begin
            state_nx = S_IDLE;
            if (rx_crc_good && !rx_fr_err) begin
              wr_nx  = base_p1;
              cmt_nx = base_p1;
              push   = 1'b1;
            end else begin
              drop  = 1'b1;
              wr_nx = cmt;
            end
          end else begin
            wr_nx    = base_p1;
            state_nx = S_RECV;
          end
        end
      end else if (state == S_DISC && rx_eof) begin
        state_nx = S_IDLE;
      end
    end
  end

  // Pointer, counter and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr       <= '0;
      cmt      <= '0;
      rd       <= '0;
      frm_cnt  <= '0;
      frm_drop <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      wr       <= wr_nx;
      cmt      <= cmt_nx;
      if (rd_adv) rd <= rd_p1;
      // commit and pop on the same cycle cancel out
      frm_cnt  <= frm_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, frm_pop};
      frm_drop <= drop;
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Simple dual-port storage, synchronous read; q holds when not read.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[base[AW-1:0]] <= wr_word;
    if (rd_req) rd_q <= mem[rd_addr];
  end
endmodule

module eth_rx_frame_mux #(
  parameter int CH_COUNT = 4,
  parameter int DEPTH    = 2048,
  parameter int CNT_W    = 16
) (
  input  logic                      p_in_clk,
  input  logic                      p_in_rst_n,
  input  logic [CH_COUNT*8-1:0]     rx_data,
  input  logic [CH_COUNT-1:0]       rx_valid,
  input  logic [CH_COUNT-1:0]       rx_sof,
  input  logic [CH_COUNT-1:0]       rx_eof,
  input  logic [CH_COUNT-1:0]       rx_crc_good,
  input  logic [CH_COUNT-1:0]       rx_fr_err,
  output logic [7:0]                m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      m_tuser,
  output logic [1:0]                m_tid,
  output logic [CH_COUNT-1:0]       frm_drop,
  output logic [CH_COUNT*CNT_W-1:0] drop_cnt
);
  localparam logic [1:0] R_ARB   = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_SEND  = 2'd2;

  logic [1:0]                rst_q;
  logic                      rst_n;
  logic [1:0]                rstate, grant, rr_ptr, cand, idx;
  logic                      cand_ok, valid_r, user_r, hs;
  logic [CH_COUNT-1:0]       avail, rd_req, rd_adv, pop;
  logic [CH_COUNT-1:0][8:0]  q;
  logic [8:0]                cur;

  // Reset asserts immediately, releases two clock edges later.
  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) rst_q <= 2'b00;
    else             rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
    eth_rx_frame_ch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_ch (
      .clk         (p_in_clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data[c*8 +: 8]),
      .rx_valid    (rx_valid[c]),
      .rx_sof      (rx_sof[c]),
      .rx_eof      (rx_eof[c]),
      .rx_crc_good (rx_crc_good[c]),
      .rx_fr_err   (rx_fr_err[c]),
      .rd_req      (rd_req[c]),
      .rd_adv      (rd_adv[c]),
      .frm_pop     (pop[c]),
      .rd_q        (q[c]),
      .avail       (avail[c]),
      .frm_drop    (frm_drop[c]),
      .drop_cnt    (drop_cnt[c*CNT_W +: CNT_W])
    );
  end

  assign cur = q[grant];
  assign hs  = valid_r & m_tready;

  // Round-robin search starting at rr_ptr; the lowest offset wins.
  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    idx     = '0;
    for (int k = CH_COUNT-1; k >= 0; k--) begin
      idx = 2'((int'(rr_ptr) + k) % CH_COUNT);
      if (avail[idx]) begin
        cand_ok = 1'b1;
        cand    = idx;
      end
    end
  end

  // RAM read control: first read in FETCH, prefetch of the next byte on
  // every non-last handshake so bytes stream back to back.
  always_comb begin
    rd_req = '0;
    rd_adv = '0;
    pop    = '0;
    if (rstate == R_FETCH) begin
      rd_req[grant] = 1'b1;
    end else if (rstate == R_SEND && hs) begin
      rd_adv[grant] = 1'b1;
      if (cur[8]) pop[grant]    = 1'b1;
      else        rd_req[grant] = 1'b1;
    end
  end

  // Arbiter / read FSM.
  always_ff @(posedge p_in_clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate  <= R_ARB;
      grant   <= '0;
      rr_ptr  <= '0;
      valid_r <= 1'b0;
      user_r  <= 1'b0;
    end else begin
      case (rstate)
        R_ARB: if (cand_ok) begin
          grant  <= cand;
          rr_ptr <= (int'(cand) == CH_COUNT-1) ? 2'd0 : cand + 2'd1;
          rstate <= R_FETCH;
        end
        R_FETCH: begin
          rstate  <= R_SEND;
          valid_r <= 1'b1;
          user_r  <= 1'b1;
        end
        R_SEND: if (hs) begin
          user_r <= 1'b0;
          if (cur[8]) begin
            valid_r <= 1'b0;
            rstate  <= R_ARB;
          end
        end
        default: rstate <= R_ARB;
      endcase
    end
  end

  // RAM output is not resettable; gate it so idle/reset outputs read as 0.
  assign m_tvalid = valid_r;
  assign m_tdata  = valid_r ? cur[7:0] : 8'h00;
  assign m_tlast  = valid_r & cur[8];
  assign m_tuser  = user_r;
  assign m_tid    = valid_r ? grant : 2'd0;
endmodule

// File: tb/tb_eth_rx_frame_mux.sv
// Directed bench for eth_rx_frame_mux: a large-FIFO instance for streaming
// tests and a DEPTH=64 instance for the overflow test.
module tb_eth_rx_frame_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rx_data = '0;
  logic [3:0]  v_big = '0, v_sm = '0, sof = '0, eof = '0, crc = '0, ferr = '0;
  logic        rdy_big = 1'b1, rdy_sm = 1'b0;

  logic [7:0]  b_tdata, s_tdata;
  logic        b_tvalid, b_tlast, b_tuser, s_tvalid, s_tlast, s_tuser;
  logic [1:0]  b_tid, s_tid;
  logic [3:0]  b_drop, s_drop;
  logic [63:0] b_cnt, s_cnt;

  eth_rx_frame_mux #(.CH_COUNT(4), .DEPTH(256), .CNT_W(16)) dut (
    .p_in_clk(clk), .p_in_rst_n(rst_n), .rx_data(rx_data), .rx_valid(v_big),
    .rx_sof(sof), .rx_eof(eof), .rx_crc_good(crc), .rx_fr_err(ferr),
    .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(rdy_big), .m_tlast(b_tlast),
    .m_tuser(b_tuser), .m_tid(b_tid), .frm_drop(b_drop), .drop_cnt(b_cnt));

  eth_rx_frame_mux #(.CH_COUNT(4), .DEPTH(64), .CNT_W(16)) dut_s (
    .p_in_clk(clk), .p_in_rst_n(rst_n), .rx_data(rx_data), .rx_valid(v_sm),
    .rx_sof(sof), .rx_eof(eof), .rx_crc_good(crc), .rx_fr_err(ferr),
    .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(rdy_sm), .m_tlast(s_tlast),
    .m_tuser(s_tuser), .m_tid(s_tid), .frm_drop(s_drop), .drop_cnt(s_cnt));

  typedef struct {logic [11:0] beat; int cyc;} rec_t;   // beat = {tid,user,last,data}
  typedef struct {int ch; int len; int base; bit good; bit fe; int beats; int drops;} vec_t;

  rec_t        bq[$], sq[$];
  int          cyc = 0;
  int          b_pulse[4] = '{default: 0};
  int          s_pulse[4] = '{default: 0};
  int          s_drop_cyc = 0;
  int          errors = 0, checks = 0;
  logic        b_stall = 1'b0;
  logic [12:0] b_prev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: records handshakes, drop pulses, and checks stall hold.
  always @(negedge clk) begin
    rec_t r;
    if (rst_n && b_tvalid && rdy_big) begin
      r.beat = {b_tid, b_tuser, b_tlast, b_tdata}; r.cyc = cyc; bq.push_back(r);
    end
    if (rst_n && s_tvalid && rdy_sm) begin
      r.beat = {s_tid, s_tuser, s_tlast, s_tdata}; r.cyc = cyc; sq.push_back(r);
    end
    for (int c = 0; c < 4; c++) begin
      if (b_drop[c]) b_pulse[c]++;
      if (s_drop[c]) begin s_pulse[c]++; s_drop_cyc = cyc; end
    end
    if (rst_n && b_stall) chk("stall_hold", {b_tvalid, b_tid, b_tuser, b_tlast, b_tdata}, b_prev);
    b_stall = rst_n && b_tvalid && !rdy_big;
    b_prev  = {b_tvalid, b_tid, b_tuser, b_tlast, b_tdata};
    cyc++;
  end

  task automatic send(input logic [3:0] mask, input int len, input int base, input bit good,
                      input bit fe, input bit sm, output int sof_cyc, output int eof_cyc);
    sof_cyc = 0; eof_cyc = 0;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < 4; c++) rx_data[c*8 +: 8] = 8'(base + i);
      if (sm) v_sm = mask; else v_big = mask;
      sof  = (i == 0) ? mask : 4'b0;
      eof  = (i == len-1) ? mask : 4'b0;
      crc  = good ? mask : 4'b0;
      ferr = fe ? mask : 4'b0;
      if (i == 0) sof_cyc = cyc;
      if (i == len-1) eof_cyc = cyc;
      @(posedge clk); #1;
    end
    v_sm = '0; v_big = '0; sof = '0; eof = '0; crc = '0; ferr = '0;
  endtask

  task automatic wait_beats(input bit sm, input int n, input int limit);
    for (int t = 0; t < limit && (sm ? sq.size() : bq.size()) < n; t++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   exp_dcnt[4] = '{default: 0};
    int   sc, ec, p0, bad;
    vt[0] = '{0, 64, 'h00, 1'b1, 1'b0, 64, 0};
    vt[1] = '{1, 12, 'h80, 1'b0, 1'b0,  0, 1};
    vt[2] = '{1, 10, 'h40, 1'b1, 1'b0, 10, 0};
    vt[3] = '{2,  6, 'h10, 1'b1, 1'b1,  0, 1};
    vt[4] = '{3,  5, 'hA0, 1'b1, 1'b0,  5, 0};

    repeat (3) @(posedge clk); #1;
    chk("rst_tvalid", b_tvalid, 0);
    chk("rst_outs", {b_tlast, b_tuser, b_tdata, b_tid, b_drop}, 0);
    chk("rst_dcnt", b_cnt, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Table-driven single-channel frames on the large instance.
    for (int v = 0; v < 5; v++) begin
      bq.delete();
      p0 = b_pulse[vt[v].ch];
      send(4'b1 << vt[v].ch, vt[v].len, vt[v].base, vt[v].good, vt[v].fe, 1'b0, sc, ec);
      if (vt[v].beats > 0) wait_beats(1'b0, vt[v].beats, vt[v].len + 40);
      repeat (10) @(posedge clk); #1;
      chk("vec_beats", bq.size(), vt[v].beats);
      for (int i = 0; i < bq.size() && i < vt[v].beats; i++)
        chk("vec_beat", bq[i].beat,
            {2'(vt[v].ch), i == 0, i == vt[v].len-1, 8'(vt[v].base + i)});
      if (vt[v].beats > 0 && bq.size() > 0) chk("vec_latency", bq[0].cyc - ec, 3);
      chk("vec_drop_pulses", b_pulse[vt[v].ch] - p0, vt[v].drops);
      exp_dcnt[vt[v].ch] += vt[v].drops;
      chk("vec_drop_cnt", b_cnt[vt[v].ch*16 +: 16], exp_dcnt[vt[v].ch]);
    end

    // All four channels commit in the same cycle: order 0..3, 2-cycle gaps.
    bq.delete();
    send(4'hF, 8, 'hC0, 1'b1, 1'b0, 1'b0, sc, ec);
    wait_beats(1'b0, 32, 120);
    chk("rr_beats", bq.size(), 32);
    for (int i = 0; i < bq.size() && i < 32; i++)
      chk("rr_beat", bq[i].beat, {2'(i / 8), (i % 8) == 0, (i % 8) == 7, 8'('hC0 + i % 8)});
    for (int k = 1; k < 4 && bq.size() == 32; k++)
      chk("rr_gap", bq[8*k].cyc - bq[8*k-1].cyc, 3);

    // After ch3, the next round begins at ch0 even with ch2 pending.
    repeat (3) @(posedge clk); #1;
    bq.delete();
    send(4'b0101, 4, 'h30, 1'b1, 1'b0, 1'b0, sc, ec);
    wait_beats(1'b0, 8, 40);
    chk("rr_next_beats", bq.size(), 8);
    if (bq.size() == 8) begin
      chk("rr_next_first", bq[0].beat[11:10], 0);
      chk("rr_next_second", bq[4].beat[11:10], 2);
    end

    // Overflow on DEPTH=64 with the sink stalled.
    rdy_sm = 1'b0;
    p0 = s_pulse[2];
    send(4'b0100, 100, 'h00, 1'b1, 1'b0, 1'b1, sc, ec);
    repeat (5) @(posedge clk); #1;
    chk("ovf_pulses", s_pulse[2] - p0, 1);
    chk("ovf_drop_at_byte65", s_drop_cyc - sc, 65);
    chk("ovf_dcnt", s_cnt[2*16 +: 16], 1);
    chk("ovf_no_output", sq.size(), 0);
    send(4'b0100, 20, 'h55, 1'b1, 1'b0, 1'b1, sc, ec);
    repeat (5) @(posedge clk); #1;
    chk("ovf_after_pulses", s_pulse[2] - p0, 1);
    rdy_sm = 1'b1;
    wait_beats(1'b1, 20, 60);
    chk("ovf_next_beats", sq.size(), 20);
    for (int i = 0; i < sq.size() && i < 20; i++)
      chk("ovf_next_beat", sq[i].beat, {2'd2, i == 0, i == 19, 8'('h55 + i)});

    // 200-byte frame drained with random backpressure.
    repeat (3) @(posedge clk); #1;
    bq.delete();
    send(4'b0010, 200, 'h10, 1'b1, 1'b0, 1'b0, sc, ec);
    for (int t = 0; t < 3000 && bq.size() < 200; t++) begin
      rdy_big = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rdy_big = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("rand_beats", bq.size(), 200);
    bad = 0;
    for (int i = 0; i < bq.size() && i < 200; i++)
      if (bq[i].beat !== {2'd1, i == 0, i == 199, 8'('h10 + i)}) bad++;
    chk("rand_stream_errs", bad, 0);

    // Reset in the middle of SEND with two frames stored.
    bq.delete();
    send(4'b0011, 10, 'h70, 1'b1, 1'b0, 1'b0, sc, ec);
    wait_beats(1'b0, 1, 20);
    chk("rst2_started", bq.size() >= 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_tvalid", b_tvalid, 0);
    chk("rst2_outs", {b_tlast, b_tuser, b_tdata, b_tid, b_drop}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bq.delete();
    repeat (30) @(posedge clk); #1;
    chk("rst2_no_output", bq.size(), 0);
    chk("rst2_tvalid_after", b_tvalid, 0);
    chk("rst2_dcnt", b_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eth_rx_frame_mux.md
Name: eth_rx_frame_mux

Overview:
Merges CH_COUNT per-port RGMII MAC receive streams into one tagged byte stream. All inputs are already in the p_in_clk domain. Each channel has its own frame-store FIFO. A frame is committed only when it ends with good CRC and no frame error; bad or overflowing frames are discarded whole. Committed frames go out whole, one at a time, in round-robin channel order, on an AXI-Stream-style output with backpressure.

Parameters:
CH_COUNT, 4, number of receive channels (1..4)
DEPTH, 2048, bytes per channel FIFO; power of 2, 64..4096
CNT_W, 16, width of each per-channel drop counter (saturating)

Ports:
p_in_clk  in  1  clock for all logic
p_in_rst_n  in  1  asynchronous active-low reset
rx_data  in  CH_COUNT*8  per-channel byte; channel c uses bits [c*8 +: 8]
rx_valid  in  CH_COUNT  byte strobe per channel
rx_sof  in  CH_COUNT  first byte of frame; qualified by rx_valid
rx_eof  in  CH_COUNT  last byte of frame; qualified by rx_valid
rx_crc_good  in  CH_COUNT  CRC OK; sampled only on the eof byte
rx_fr_err  in  CH_COUNT  frame error; sampled only on the eof byte
m_tdata  out  8  output byte
m_tvalid  out  1  output byte valid
m_tready  in  1  sink accepts the byte
m_tlast  out  1  last byte of frame
m_tuser  out  1  first byte of frame
m_tid  out  2  source channel of the current frame
frm_drop  out  CH_COUNT  1-cycle pulse when a frame is discarded
drop_cnt  out  CH_COUNT*CNT_W  per-channel saturating count of dropped frames

Behaviour:
- Reset values: all FIFO pointers, frame counts, drop_cnt and arbiter pointer = 0. m_tvalid, m_tlast, m_tuser, m_tdata, m_tid and frm_drop = 0. Any partial or stored frame is lost. Reset is asserted asynchronously and released synchronously.
- FIFO entry format: 9 bits = {last, byte}.
- Per-channel pointers (log2(DEPTH)+1 bits, wrap naturally): wr, commit, rd.
- Free space = DEPTH - (wr - rd).
- Write FSM per channel has three states: IDLE, RECV, DISCARD.
  - IDLE: rx_valid&rx_sof -> write byte, go to RECV. If eof is on the same byte, evaluate end-of-frame immediately. rx_valid without sof -> byte ignored, no drop counted.
  - RECV: each rx_valid byte is written at wr and wr increments.
    - sof while in RECV: wr rewinds to commit, frame restarts with this byte, drop pulse + count.
    - Byte arrives with free space = 0: wr rewinds to commit, go to DISCARD, drop pulse + count.
  - DISCARD: bytes are ignored until eof, then go to IDLE. A sof in DISCARD starts a new frame (go to RECV).
- End-of-frame (eof byte in RECV):
  - crc_good=1 and fr_err=0: write the byte with last=1, commit <= wr+1, frame_cnt+1, go to IDLE.
  - Otherwise: wr <= commit, drop pulse + count, go to IDLE.
- frm_drop[c] pulses on the cycle after the dropping event. drop_cnt saturates at all-ones.
- Read/arbiter FSM has three states: ARB, FETCH, SEND.
  - ARB: grant the first channel with frame_cnt>0, searching from (last_grant+1) mod CH_COUNT. No candidate -> stay in ARB.
  - FETCH: one-cycle synchronous RAM read.
  - SEND: present the byte with m_tid = grant. m_tuser=1 on the frame's first byte.
  - Outputs hold stable while m_tvalid&!m_tready.
  - On handshake, rd increments and the next byte is pre-fetched so back-to-back bytes stream with no gap.
  - Handshake of the last=1 byte: frame_cnt-1, m_tvalid drops, return to ARB.
  - Inter-frame gap is exactly 2 idle cycles (ARB, FETCH).
- Commit and read-side decrement of frame_cnt in the same cycle on the same channel: net 0, no loss.
- Write into the read region is impossible, because free space uses rd, not commit.
- Storage uses inferable block RAM, one per channel.

Test Plan:
- Ch0 sends a 64-byte frame 0x00..0x3F with crc_good=1, m_tready=1. Required: 64 bytes out in order, m_tuser on 0x00, m_tlast on 0x3F, m_tid=0, first output byte 3 cycles after eof.
- Ch1 frame with crc_good=0, then a good 10-byte frame. Required: frm_drop[1] pulses once, drop_cnt[1]=1, only the 10-byte frame appears, with m_tid=1.
- All 4 channels each commit one 8-byte frame in the same cycle. Required: output order 0,1,2,3, each separated by exactly 2 idle cycles. The next round after a new ch0 frame starts at ch0.
- DEPTH=64, m_tready=0, ch2 sends a 100-byte frame. Required: drop on byte 65, ch2 returns to DISCARD then IDLE at eof. A subsequent 20-byte frame is committed and output intact once m_tready=1.
- Random m_tready (50%) during a 200-byte frame. Required: no byte lost or duplicated, and m_tdata/m_tid stay stable while stalled.
- Reset asserted mid-SEND with 2 frames stored. Required: outputs go to 0 immediately. After release with no new input, m_tvalid stays 0 and drop_cnt=0.
